// File: rtl/clock_period_meter.sv
`timescale 1ns/1ps
// clock_period_meter
// Measures a slow, clock-like input in cycles of the fast clock clk_in.
// The input is synchronised and edge-detected, and the period and high time
// are published once per period. Loss of the input is flagged after TIMEOUT
// cycles without a rising edge.
//
// Ports:
//   clk_in     - the only clock, rising edge
//   rst        - asynchronous active-high reset
//   sig_in     - measured signal, asynchronous to clk_in
//   rise_pulse - one-cycle pulse per synchronised rising edge
//   fall_pulse - one-cycle pulse per synchronised falling edge
//   period     - clk_in cycles between the last two rising edges
//   high_time  - clk_in cycles from the last rising edge to the next falling edge
//   meas_valid - one-cycle pulse when period/high_time update
//   locked     - high while periodic measurements are valid
//   lost       - high after a timeout, cleared by the next rising edge
module clock_period_meter #(
   parameter int CNT_WIDTH   = 16,
   parameter int TIMEOUT     = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 sig_in,
   output logic                 rise_pulse,
   output logic                 fall_pulse,
   output logic [CNT_WIDTH-1:0] period,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic                 meas_valid,
   output logic                 locked,
   output logic                 lost
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Last legal counter value; reaching it without a rising edge is a timeout.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   e_rise;
   logic                   e_fall;

   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [CNT_WIDTH-1:0]   cnt_d;
   logic [CNT_WIDTH-1:0]   cnt_inc;
   logic [CNT_WIDTH-1:0]   ht_acc_q;
   logic [CNT_WIDTH-1:0]   ht_acc_d;
   logic                   publish;
   logic                   timeout;

   // Synchroniser chain followed by one history flop for edge detection.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, regardless of statement order.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign e_rise = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign e_fall = ~sync_q[SYNC_STAGES-1] & hist_q;

   // State register.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, counter and high-time accumulator.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ht_acc_d = ht_acc_q;
      publish  = 1'b0;
      timeout  = 1'b0;
      // Cannot wrap: cnt never exceeds TIMEOUT-1 <= 2^CNT_WIDTH-2.
      cnt_inc  = cnt_q + CNT_WIDTH'(1);

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (e_rise) begin
               state_d  = ARMED;
               ht_acc_d = '0;
            end
         end
         ARMED, LOCKED: begin
            if (e_rise) begin
               // A rise on the timeout cycle still counts as a normal edge.
               state_d  = LOCKED;
               publish  = 1'b1;
               cnt_d    = '0;
               ht_acc_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = IDLE;
               timeout  = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
               if (e_fall) begin
                  ht_acc_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Counter, accumulator and registered outputs.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         ht_acc_q   <= '0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         lost       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         ht_acc_q   <= ht_acc_d;
         rise_pulse <= e_rise;
         fall_pulse <= e_fall;
         meas_valid <= publish;
         if (publish) begin
            period    <= cnt_inc;
            high_time <= ht_acc_q;
            locked    <= 1'b1;
         end
         if (timeout) begin
            locked <= 1'b0;
            lost   <= 1'b1;
         end
         if (e_rise) begin
            lost <= 1'b0;
         end
      end
   end

endmodule
